// File: rtl/rbus_pkt_buffer_if.sv
// rbus word-stream interface: one direction of packet words plus the
// per-priority room / drain status that flows back against it.
//   stb   word valid
//   sof   header word marker (qualified by stb)
//   data  packet word
//   rdy   bit p: receiver can take one maximum-length packet of priority p
//   rdy_e bit p: receiver side has drained priority p
// master drives stb/sof/data; slave drives rdy/rdy_e.
interface rbus_pkt_buffer_if #(
  parameter int DATA_W = 72
);
  logic              stb;
  logic              sof;
  logic [DATA_W-1:0] data;
  logic [1:0]        rdy;
  logic [1:0]        rdy_e;

  modport master (output stb, sof, data, input rdy, rdy_e);
  modport slave  (input stb, sof, data, output rdy, rdy_e);
endinterface

// File: rtl/rbus_pkt_buffer.sv
// Store-and-forward packet buffer for one rbus channel with two priority
// queues. A packet becomes visible to the output side only once its last
// word has been written; the output side then streams it back-to-back when
// the sink has room for that priority, priority 1 first.
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   up     slave side: incoming words; rdy/rdy_e report queue room / drain
//   dn     master side: outgoing words; rdy/rdy_e from the sink
//   ff_err sticky protocol / overflow error, cleared only by rst
// Header word: bit 71 = priority, bits [67:64] = payload length L.
module rbus_pkt_buffer #(
  parameter int DEPTH  = 32,
  parameter int MAXPKT = 16
) (
  input  logic              clk,
  input  logic              rst,
  rbus_pkt_buffer_if.slave  up,
  rbus_pkt_buffer_if.master dn,
  output logic              ff_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAXPKT_P = (AW+1)'(MAXPKT);

  typedef logic [AW:0] ptr_t;
  typedef enum logic {IN_IDLE, IN_RECV} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

  logic [71:0]      mem [2][DEPTH];
  logic [1:0][AW:0] wr_ptr, commit_ptr, rd_ptr;

  in_state_t  in_state, in_nxt;
  out_state_t out_state, out_nxt;

  logic       cur_q;
  logic [3:0] remaining;
  logic       discard;
  logic       hdr, wr_word, rewind, pkt_end, proto_err, wq;
  logic [3:0] in_len;
  ptr_t       wp_base, wp_next;
  logic       full_w, do_write, drop_pkt;

  logic          sel, sel_nxt, first, load;
  logic [3:0]    out_cnt;
  logic [1:0]    avail;
  logic [AW-1:0] rd_idx;
  logic [71:0]   rd_word;
  logic [1:0]    rdy_c, rdy_e_c;

  assign in_len = up.data[67:64];

  // Input stage: word classification and next state
  always_comb begin
    in_nxt    = in_state;
    hdr       = 1'b0;
    wr_word   = 1'b0;
    rewind    = 1'b0;
    pkt_end   = 1'b0;
    proto_err = 1'b0;
    wq        = cur_q;
    if (up.stb) begin
      if (up.sof) begin
        // A header while still receiving abandons the partial packet.
        rewind    = (in_state == IN_RECV);
        proto_err = (in_state == IN_RECV);
        hdr       = 1'b1;
        wr_word   = 1'b1;
        wq        = up.data[71];
        pkt_end   = (in_len == 4'd0);
        in_nxt    = (in_len == 4'd0) ? IN_IDLE : IN_RECV;
      end else if (in_state == IN_RECV) begin
        wr_word = 1'b1;
        pkt_end = (remaining == 4'd1);
        if (remaining == 4'd1) in_nxt = IN_IDLE;
      end else begin
        proto_err = 1'b1;
      end
    end
  end

  // The write address must see a same-cycle rewind so a new header lands
  // exactly where the abandoned packet started.
  always_comb begin
    wp_base  = (rewind && (wq == cur_q)) ? commit_ptr[wq] : wr_ptr[wq];
    full_w   = (wp_base[AW] != rd_ptr[wq][AW]) &&
               (wp_base[AW-1:0] == rd_ptr[wq][AW-1:0]);
    do_write = wr_word && !full_w;
    drop_pkt = (discard && !hdr) || (wr_word && full_w);
    wp_next  = wp_base + ptr_t'(do_write);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_state <= IN_IDLE;
    else     in_state <= in_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q      <= 1'b0;
      remaining  <= 4'd0;
      discard    <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      ff_err     <= 1'b0;
    end else begin
      if (proto_err || (wr_word && full_w)) ff_err <= 1'b1;
      if (rewind) wr_ptr[cur_q] <= commit_ptr[cur_q];
      if (wr_word) begin
        // An overflowed packet is rolled back once its last word arrives.
        if (pkt_end && drop_pkt) wr_ptr[wq] <= commit_ptr[wq];
        else                     wr_ptr[wq] <= wp_next;
        if (pkt_end && !drop_pkt) commit_ptr[wq] <= wp_next;
        discard   <= drop_pkt && !pkt_end;
        remaining <= hdr ? in_len : remaining - 4'd1;
      end
      if (hdr) cur_q <= wq;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wq][wp_base[AW-1:0]] <= up.data;
  end

  // Output stage: packet selection at packet boundaries
  always_comb begin
    for (int q = 0; q < 2; q++)
      avail[q] = (commit_ptr[q] != rd_ptr[q]) && dn.rdy[q];
    out_nxt = out_state;
    sel_nxt = sel;
    load    = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (avail[1]) begin
          sel_nxt = 1'b1;
          out_nxt = OUT_SEND;
          load    = 1'b1;
        end else if (avail[0]) begin
          sel_nxt = 1'b0;
          out_nxt = OUT_SEND;
          load    = 1'b1;
        end
      end
      OUT_SEND: begin
        if (out_cnt == 4'd0) out_nxt = OUT_IDLE;
      end
      default: out_nxt = OUT_IDLE;
    endcase
    rd_idx  = rd_ptr[sel_nxt][AW-1:0];
    rd_word = mem[sel_nxt][rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_state <= OUT_IDLE;
    else     out_state <= out_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      sel     <= 1'b0;
      out_cnt <= 4'd0;
      first   <= 1'b0;
      dn.stb  <= 1'b0;
      dn.sof  <= 1'b0;
      dn.data <= '0;
    end else begin
      sel    <= sel_nxt;
      dn.stb <= 1'b0;
      dn.sof <= 1'b0;
      if (load) begin
        out_cnt <= rd_word[67:64];
        first   <= 1'b1;
      end
      if (out_state == OUT_SEND) begin
        dn.stb      <= 1'b1;
        dn.sof      <= first;
        dn.data     <= rd_word;
        first       <= 1'b0;
        rd_ptr[sel] <= rd_ptr[sel] + ptr_t'(1);
        out_cnt     <= out_cnt - 4'd1;
      end
    end
  end

  // Status stage: registered room and drain flags
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      rdy_c[q]   = (DEPTH_P - (wr_ptr[q] - rd_ptr[q])) >= MAXPKT_P;
      rdy_e_c[q] = (rd_ptr[q] == wr_ptr[q]) &&
                   !((in_state == IN_RECV) && (cur_q == 1'(q))) &&
                   dn.rdy_e[q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up.rdy   <= 2'b00;
      up.rdy_e <= 2'b00;
    end else begin
      up.rdy   <= rdy_c;
      up.rdy_e <= rdy_e_c;
    end
  end
endmodule

// File: tb/tb_rbus_pkt_buffer.sv
module tb_rbus_pkt_buffer;
  logic clk = 1'b0;
  logic rst;
  logic ff_err;

  always #5 clk = ~clk;

  rbus_pkt_buffer_if up ();
  rbus_pkt_buffer_if dn ();

  rbus_pkt_buffer #(.DEPTH(32), .MAXPKT(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .up     (up),
    .dn     (dn),
    .ff_err (ff_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int out_cnt = 0;
  int last_cyc = 0;
  int sof_cyc = 0;
  logic mon_p = 1'b0;
  logic [72:0] sb0 [$];
  logic [72:0] sb1 [$];
  bit hdr_log [$];
  int hdr_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Output monitor: every emitted word is matched against the scoreboard
  // queue of the priority announced by its packet header.
  always @(negedge clk) begin
    logic [72:0] e;
    if (!rst && dn.stb) begin
      if (dn.sof) begin
        mon_p = dn.data[71];
        hdr_log.push_back(dn.data[71]);
        hdr_cyc.push_back(cyc);
      end
      out_cnt++;
      last_cyc = cyc;
      if (mon_p) begin
        chk("sb1_has_word", 73'(sb1.size() != 0), 73'd1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          chk("p1_word", {dn.sof, dn.data}, e);
        end
      end else begin
        chk("sb0_has_word", 73'(sb0.size() != 0), 73'd1);
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          chk("p0_word", {dn.sof, dn.data}, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [71:0] rnd_word();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [71:0] hdr_word(input bit p, input logic [3:0] len);
    logic [71:0] w;
    w = rnd_word();
    w[71] = p;
    w[67:64] = len;
    return w;
  endfunction

  function automatic int hc(input int idx);
    return (idx < hdr_cyc.size()) ? hdr_cyc[idx] : -1000;
  endfunction

  function automatic int hl(input int idx);
    return (idx < hdr_log.size()) ? int'(hdr_log[idx]) : 2;
  endfunction

  task automatic drive_word(input logic sof, input logic [71:0] w);
    @(posedge clk); #1;
    up.stb = 1'b1;
    up.sof = sof;
    up.data = w;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    up.stb = 1'b0;
    up.sof = 1'b0;
  endtask

  task automatic push_pkt(input bit p, input logic [72:0] pkt [$]);
    foreach (pkt[i]) begin
      if (p) sb1.push_back(pkt[i]);
      else   sb0.push_back(pkt[i]);
    end
  endtask

  task automatic send_pkt(input bit p, input logic [3:0] len);
    logic [72:0] pkt [$];
    logic [71:0] w;
    w = hdr_word(p, len);
    drive_word(1'b1, w);
    sof_cyc = cyc + 1;
    pkt.push_back({1'b1, w});
    for (int i = 0; i < int'(len); i++) begin
      w = rnd_word();
      drive_word(1'b0, w);
      pkt.push_back({1'b0, w});
    end
    drive_idle();
    push_pkt(p, pkt);
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (out_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("wait_out", 73'(out_cnt >= n), 73'd1);
  endtask

  initial begin
    int base, hbase;
    bit found;
    logic [71:0] w;
    logic [72:0] pkt [$];

    rst = 1'b1;
    up.stb = 1'b0;
    up.sof = 1'b0;
    up.data = '0;
    dn.rdy = 2'b00;
    dn.rdy_e = 2'b11;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_i_rdy", 73'(up.rdy), 73'd0);
    chk("rst_i_rdye", 73'(up.rdy_e), 73'd0);
    chk("rst_o_stb", 73'(dn.stb), 73'd0);
    chk("rst_o_sof", 73'(dn.sof), 73'd0);
    chk("rst_o_data", 73'(dn.data), 73'd0);
    chk("rst_ff_err", 73'(ff_err), 73'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", 73'(up.rdy), 73'd0);
    @(negedge clk);
    chk("rdy_after_rst", 73'(up.rdy), 73'd3);
    chk("rdye_after_rst", 73'(up.rdy_e), 73'd3);

    // single packet latency and contiguity
    dn.rdy = 2'b01;
    base = out_cnt;
    hbase = hdr_cyc.size();
    send_pkt(1'b0, 4'd3);
    wait_out(base + 4, 50);
    chk("single_latency", 73'(hc(hbase) - sof_cyc), 73'd5);
    chk("single_contig", 73'(last_cyc - hc(hbase)), 73'd3);

    // priority ordering and inter-packet gap
    dn.rdy = 2'b00;
    base = out_cnt;
    hbase = hdr_cyc.size();
    send_pkt(1'b0, 4'd2);
    send_pkt(1'b1, 4'd2);
    repeat (6) @(negedge clk);
    chk("held_not_rdy", 73'(out_cnt), 73'(base));
    dn.rdy = 2'b11;
    wait_out(base + 6, 50);
    chk("prio_first_p1", 73'(hl(hbase)), 73'd1);
    chk("prio_second_p0", 73'(hl(hbase + 1)), 73'd0);
    chk("prio_gap", 73'(hc(hbase + 1) - hc(hbase)), 73'd4);

    // fill queue 0 with two maximum packets
    dn.rdy = 2'b00;
    base = out_cnt;
    send_pkt(1'b0, 4'd15);
    repeat (3) @(negedge clk);
    chk("fill_rdy_16free", 73'(up.rdy), 73'd3);
    pkt.delete();
    w = hdr_word(1'b0, 4'd15);
    drive_word(1'b1, w);
    pkt.push_back({1'b1, w});
    for (int i = 1; i <= 15; i++) begin
      w = rnd_word();
      drive_word(1'b0, w);
      pkt.push_back({1'b0, w});
      @(negedge clk);
      if (i == 1) chk("fill_rdy_lag", 73'(up.rdy), 73'd3);
      if (i == 2) chk("fill_rdy_fall", 73'(up.rdy), 73'd2);
    end
    drive_idle();
    push_pkt(1'b0, pkt);
    repeat (3) @(negedge clk);
    chk("fill_rdy_full", 73'(up.rdy), 73'd2);
    chk("fill_no_err", 73'(ff_err), 73'd0);
    dn.rdy = 2'b01;
    wait_out(base + 32, 120);
    repeat (3) @(negedge clk);
    chk("fill_rdy_recovered", 73'(up.rdy), 73'd3);

    // protocol error: header inside a packet
    base = out_cnt;
    drive_word(1'b1, hdr_word(1'b0, 4'd5));
    drive_word(1'b0, rnd_word());
    w = hdr_word(1'b0, 4'd0);
    drive_word(1'b1, w);
    @(negedge clk);
    chk("perr_before", 73'(ff_err), 73'd0);
    drive_idle();
    sb0.push_back({1'b1, w});
    @(negedge clk);
    chk("perr_set", 73'(ff_err), 73'd1);
    wait_out(base + 1, 30);
    repeat (5) @(negedge clk);
    chk("perr_only_short", 73'(out_cnt), 73'(base + 1));
    chk("perr_sticky", 73'(ff_err), 73'd1);

    // drain status
    chk("rdye_empty", 73'(up.rdy_e), 73'd3);
    dn.rdy = 2'b10;
    pkt.delete();
    w = hdr_word(1'b1, 4'd1);
    drive_word(1'b1, w);
    pkt.push_back({1'b1, w});
    @(negedge clk);
    w = rnd_word();
    drive_word(1'b0, w);
    pkt.push_back({1'b0, w});
    @(negedge clk);
    chk("rdye_lag", 73'(up.rdy_e[1]), 73'd1);
    drive_idle();
    push_pkt(1'b1, pkt);
    @(negedge clk);
    chk("rdye_recv", 73'(up.rdy_e[1]), 73'd0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (dn.stb && !dn.sof) found = 1'b1;
    end
    chk("rdye_last_seen", 73'(found), 73'd1);
    chk("rdye_last_word", 73'(up.rdy_e[1]), 73'd0);
    @(negedge clk);
    chk("rdye_back", 73'(up.rdy_e[1]), 73'd1);
    dn.rdy_e = 2'b01;
    repeat (2) @(negedge clk);
    chk("rdye_sink_busy", 73'(up.rdy_e), 73'd1);
    dn.rdy_e = 2'b11;

    // reset in the middle of an output packet
    dn.rdy = 2'b01;
    base = out_cnt;
    send_pkt(1'b0, 4'd7);
    wait_out(base + 3, 40);
    #1 rst = 1'b1;
    #1;
    chk("midrst_o_stb", 73'(dn.stb), 73'd0);
    chk("midrst_ff_err", 73'(ff_err), 73'd0);
    chk("midrst_i_rdy", 73'(up.rdy), 73'd0);
    sb0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_rdy_back", 73'(up.rdy), 73'd3);
    chk("midrst_rdye_back", 73'(up.rdy_e), 73'd3);
    dn.rdy = 2'b11;
    base = out_cnt;
    repeat (8) @(negedge clk);
    chk("midrst_queues_empty", 73'(out_cnt), 73'(base));

    chk("sb0_drained", 73'(sb0.size()), 73'd0);
    chk("sb1_drained", 73'(sb1.size()), 73'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rbus_pkt_buffer.md
# rbus_pkt_buffer

Store-and-forward packet buffer for one rbus channel, placed directly downstream of each output of the N-to-M channel-count mux stage. It holds two priority queues. A packet is forwarded only after it has been received completely, and only when the sink signals room for it. The buffer decouples the mux stage's arbitration timing from the consuming endpoint and aggregates drain status back upstream.

## Interface
- DEPTH, 32: words per priority queue; power of two, ≥ 2·MAXPKT.
- MAXPKT, 16: maximum packet length in words (header plus payload); fixed by the 4-bit length field.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_stb  in  1  input word valid.
- i_sof  in  1  first word (header) of a packet; qualified by i_stb.
- i_data  in  72  input word. Header fields:
  - bit 71: priority p (0/1).
  - bits [67:64]: payload length L (0..15); packet is 1+L words.
- i_rdy  out  2  bit p: queue p can accept one MAXPKT-word packet.
- i_rdyE  out  2  bit p: queue p is empty, no packet is being assembled into it, and o_rdyE[p]=1.
- o_stb  out  1  output word valid.
- o_sof  out  1  output header marker.
- o_data  out  72  output word.
- o_rdy  in  2  bit p: sink accepts one MAXPKT-word packet of priority p.
- o_rdyE  in  2  sink drain status for priority p; propagated into i_rdyE.
- ff_err  out  1  sticky error flag; cleared only by rst.

## Operation
**Word framing**
- Packets are contiguous: i_stb is high for 1+L consecutive cycles.
- Mid-packet there is no backpressure. The upstream sender checks i_rdy[p] only before issuing a header.

**Queues**
- Two queues, one per priority, each DEPTH×72 RAM.
- Pointers per queue:
  - wr_ptr: write position.
  - commit_ptr: end of the last complete packet.
  - rd_ptr: read position.
- Pointers are log2(DEPTH)+1 bits, including a wrap bit.
  - full: equal index with differing wrap bit.
  - free = DEPTH − (wr_ptr − rd_ptr), computed modulo 2^(log2(DEPTH)+1).

**Input FSM** (states IDLE, RECV)
- IDLE:
  - stb & sof: latch p and L, write the header, remaining = L. Go to RECV if L>0; otherwise commit immediately and stay in IDLE.
  - stb & !sof: protocol error. Word is dropped, ff_err set.
- RECV:
  - stb & !sof: write the word, decrement remaining. At 0, set commit_ptr[p] = wr_ptr[p] and return to IDLE.
  - stb & sof: protocol error. wr_ptr[p] rewinds to commit_ptr[p], discarding the partial packet, ff_err set. The new header is then processed as in IDLE in the same cycle.
  - !stb: wait, no error.
- Write to a full queue: the word is dropped, ff_err set, and the partial packet is rewound as above when its end arrives.

**Output FSM** (states IDLE, SEND)
- IDLE selects a packet at a packet boundary:
  - Priority 1 is chosen if commit_ptr[1] ≠ rd_ptr[1] and o_rdy[1]=1.
  - Otherwise priority 0 is chosen under the same conditions for queue 0.
  - The header's L is read; the FSM goes to SEND.
- SEND emits 1+L words back-to-back:
  - o_sof on the first word only.
  - o_rdy is ignored until the packet ends.
  - After the last word, return to IDLE.
- Packets of priority 0 and 1 never interleave. No starvation protection.

**Status**
- i_rdy[p] = registered (free[p] ≥ MAXPKT).
- i_rdyE[p] = registered (rd_ptr[p]==wr_ptr[p] & not in RECV for p & o_rdyE[p]).

**Reset**
- All pointers 0; both FSMs IDLE.
- o_stb, o_sof, ff_err = 0; o_data = 0.
- i_rdy and i_rdyE = 0 during reset. Both rise at the first clock edge after rst falls (i_rdyE only if o_rdyE is high).
- rst asserted mid-packet discards all contents, with no error.

## Timing
- RAM write occurs at the edge where i_stb is sampled.
- Last input word at edge t → commit at edge t. Output IDLE can select at t+1 → o_stb/o_sof header registered at t+2.
- Output words are registered: o_* change only on clock edges, one word per cycle.
- Back-to-back output packets: one IDLE cycle between packets (o_stb low for exactly one cycle).
- i_rdy/i_rdyE lag pointer changes by one cycle. Headroom of MAXPKT keeps this safe.

## Test plan
- **Single packet:** priority 0, L=3, sof at cycle 0, o_rdy=2'b01 → header on o_* at cycle 5, 4 words contiguous, o_sof only on the first, data bit-exact.
- **Priority:** a p0 packet (L=2) and a p1 packet (L=2), both committed while o_rdy=0, then o_rdy=2'b11 → p1 emitted first, one idle cycle, then p0.
- **Fill:** send two L=15 p0 packets with o_rdy=0, DEPTH=32 → i_rdy[0] falls one cycle after free drops below 16; i_rdy[1] stays 1.
- **Protocol error:** p0 L=5, sof re-asserted at the 3rd word with a new L=0 header → ff_err=1 from the next cycle, only the L=0 packet emitted.
- **Drain status:**
  - o_rdyE=2'b11, queue empty → i_rdyE=2'b11.
  - Start of a p1 packet → i_rdyE[1]=0 the next cycle, returning to 1 one cycle after its last output word.
- **Reset mid-operation:** rst during SEND of an L=7 packet → o_stb=0 immediately, ff_err=0, queues empty, i_rdy=2'b11 one cycle after rst release.
